// File: rtl/wb_pkg.sv
// Shared encodings for the registered writeback stage: result sources,
// load-extension modes and controller states.
package wb_pkg;

  typedef logic [1:0] wb_src_t;
  typedef logic [1:0] wb_ld_mode_t;

  localparam wb_src_t SRC_ALU  = 2'b00;
  localparam wb_src_t SRC_MEM  = 2'b01;
  localparam wb_src_t SRC_PC   = 2'b10;
  localparam wb_src_t SRC_COND = 2'b11;

  localparam wb_ld_mode_t LD_WORD = 2'b00;
  localparam wb_ld_mode_t LD_BZX  = 2'b01;
  localparam wb_ld_mode_t LD_BSX  = 2'b10;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load extender: word pass-through, or the low byte
// zero- or sign-extended to the full datapath width.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        ld_mode,
  output logic [DATA_W-1:0] ext_data
);

  // Byte modes fill the whole word first, then overlay the low byte,
  // which keeps DATA_W == 8 legal (no zero-width replication).
  always_comb begin
    ext_data = mem_rdata;
    case (ld_mode)
      LD_WORD: begin
        ext_data = mem_rdata;
      end
      LD_BZX: begin
        ext_data      = {DATA_W{1'b0}};
        ext_data[7:0] = mem_rdata[7:0];
      end
      LD_BSX: begin
        ext_data      = {DATA_W{mem_rdata[7]}};
        ext_data[7:0] = mem_rdata[7:0];
      end
      default: begin
        ext_data = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage_seq.sv
// Registered writeback stage: accepts one retiring op per cycle, parks on
// outstanding loads, and drives a registered register-file write port.
module wb_stage_seq
  import wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_src,
  input  logic [1:0]        in_ld_mode,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_pc_inc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_cond,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  retired
);

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [REG_AW-1:0] pend_rd_r;
  logic              pend_we_r;
  logic [1:0]        pend_mode_r;

  logic              rf_we_r;
  logic [REG_AW-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic [CNT_W-1:0]  retired_r;

  logic              idle_s;
  logic              accept_s;
  logic              complete_s;
  logic              go_wait_s;
  logic              wr_we_s;
  logic [REG_AW-1:0] wr_rd_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] ext_s;
  logic [1:0]        ext_mode_s;

  assign idle_s   = (state_r == ST_IDLE);
  assign accept_s = in_valid && idle_s;
  assign in_ready = idle_s;

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign retired  = retired_r;

  // A parked load must be extended with the mode captured at accept time.
  always_comb begin
    ext_mode_s = in_ld_mode;
    if (idle_s) begin
      ext_mode_s = in_ld_mode;
    end else begin
      ext_mode_s = pend_mode_r;
    end
  end

  wb_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .mem_rdata (mem_rdata),
    .ld_mode   (ext_mode_s),
    .ext_data  (ext_s)
  );

  // Result select for an op accepted this cycle.
  always_comb begin
    sel_data_s = in_data;
    case (in_src)
      SRC_ALU: begin
        sel_data_s = in_data;
      end
      SRC_MEM: begin
        sel_data_s = ext_s;
      end
      SRC_PC: begin
        sel_data_s = in_pc_inc;
      end
      SRC_COND: begin
        sel_data_s    = {DATA_W{1'b0}};
        sel_data_s[0] = in_cond;
      end
      default: begin
        sel_data_s = in_data;
      end
    endcase
  end

  // Decide whether an op completes this cycle and which fields it writes.
  always_comb begin
    complete_s = 1'b0;
    go_wait_s  = 1'b0;
    wr_we_s    = in_reg_write;
    wr_rd_s    = in_rd;
    wr_data_s  = sel_data_s;
    if (idle_s) begin
      if (accept_s) begin
        if ((in_src == SRC_MEM) && !mem_done) begin
          go_wait_s = 1'b1;
        end else begin
          complete_s = 1'b1;
        end
      end else begin
        complete_s = 1'b0;
      end
    end else begin
      complete_s = mem_done;
      wr_we_s    = pend_we_r;
      wr_rd_s    = pend_rd_r;
      wr_data_s  = ext_s;
    end
  end

  // Next-state selection between IDLE and WAIT_MEM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_wait_s) begin
          state_nxt_s = ST_WAIT_MEM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_MEM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Controller state and the fields of a parked load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pend_rd_r   <= {REG_AW{1'b0}};
      pend_we_r   <= 1'b0;
      pend_mode_r <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      if (go_wait_s) begin
        pend_rd_r   <= in_rd;
        pend_we_r   <= in_reg_write;
        pend_mode_r <= in_ld_mode;
      end
    end
  end

  // Write port and retire counter; address/data hold between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_AW{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
      retired_r  <= {CNT_W{1'b0}};
    end else begin
      rf_we_r <= complete_s && wr_we_s;
      if (complete_s) begin
        rf_waddr_r <= wr_rd_s;
        rf_wdata_r <= wr_data_s;
        retired_r  <= retired_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_seq.sv
// Bench for wb_stage_seq: a transaction-level model checked every cycle
// against a 16-bit-counter and a 4-bit-counter instance sharing stimulus.
module tb_wb_stage_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_src = 2'b00;
  logic [1:0]  in_ld_mode = 2'b00;
  logic        in_reg_write = 1'b0;
  logic [2:0]  in_rd = 3'd0;
  logic [15:0] in_pc_inc = 16'h0000;
  logic [15:0] in_data = 16'h0000;
  logic        in_cond = 1'b0;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  logic        rdy_a, we_a, rdy_b, we_b;
  logic [2:0]  waddr_a, waddr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [15:0] ret_a;
  logic [3:0]  ret_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_stage_seq #(.DATA_W(16), .REG_AW(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_src(in_src),
    .in_ld_mode(in_ld_mode), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_pc_inc(in_pc_inc), .in_data(in_data), .in_cond(in_cond), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .rf_we(we_a), .rf_waddr(waddr_a), .rf_wdata(wdata_a),
    .retired(ret_a));

  wb_stage_seq #(.DATA_W(16), .REG_AW(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_src(in_src),
    .in_ld_mode(in_ld_mode), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_pc_inc(in_pc_inc), .in_data(in_data), .in_cond(in_cond), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .rf_we(we_b), .rf_waddr(waddr_b), .rf_wdata(wdata_b),
    .retired(ret_b));

  // Load extension by arithmetic on the low byte.
  function automatic logic [15:0] m_ext(input logic [15:0] d, input logic [1:0] m);
    logic [15:0] b;
    b = d & 16'h00FF;
    if (m == 2'b01) return b;
    else if (m == 2'b10) return (b >= 16'd128) ? b + 16'hFF00 : b;
    else return d;
  endfunction

  // Model: one outstanding load at most; completions recorded as transactions.
  bit          model_ok = 1'b0;
  bit          busy = 1'b0;
  logic [2:0]  p_rd;
  logic        p_we;
  logic [1:0]  p_mode;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_waddr = 3'd0;
  logic [15:0] exp_wdata = 16'h0000;
  logic [31:0] exp_cnt = 32'd0;

  always @(posedge clk) begin
    bit          done;
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
    done = 1'b0; w = 1'b0; a = 3'd0; d = 16'h0000;
    if (rst) begin
      model_ok = 1'b1;
      busy = 1'b0;
      exp_we = 1'b0; exp_waddr = 3'd0; exp_wdata = 16'h0000; exp_cnt = 32'd0;
    end else begin
      if (busy) begin
        if (mem_done) begin
          done = 1'b1; w = p_we; a = p_rd; d = m_ext(mem_rdata, p_mode); busy = 1'b0;
        end
      end else if (in_valid) begin
        if (in_src == 2'b01 && !mem_done) begin
          busy = 1'b1; p_rd = in_rd; p_we = in_reg_write; p_mode = in_ld_mode;
        end else begin
          done = 1'b1; w = in_reg_write; a = in_rd;
          case (in_src)
            2'b00: d = in_data;
            2'b01: d = m_ext(mem_rdata, in_ld_mode);
            2'b10: d = in_pc_inc;
            default: d = {15'd0, in_cond};
          endcase
        end
      end
      exp_we = done && w;
      if (done) begin
        exp_waddr = a; exp_wdata = d; exp_cnt = exp_cnt + 32'd1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if (rdy_a !== !busy || we_a !== exp_we || waddr_a !== exp_waddr ||
          wdata_a !== exp_wdata || ret_a !== exp_cnt[15:0] ||
          rdy_b !== !busy || we_b !== exp_we || waddr_b !== exp_waddr ||
          wdata_b !== exp_wdata || ret_b !== exp_cnt[3:0]) begin
        miscompares++;
        $display("FAIL model t=%0t: got rdy=%b we=%b wa=%0d wd=%h ret=%h/%h expected rdy=%b we=%b wa=%0d wd=%h ret=%h",
                 $time, rdy_a, we_a, waddr_a, wdata_a, ret_a, ret_b,
                 !busy, exp_we, exp_waddr, exp_wdata, exp_cnt[15:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; mem_done = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] src, input logic [1:0] mode, input logic we,
                       input logic [2:0] rd, input logic [15:0] data, input logic [15:0] pc,
                       input logic cond);
    in_valid = 1'b1; in_src = src; in_ld_mode = mode; in_reg_write = we;
    in_rd = rd; in_data = data; in_pc_inc = pc; in_cond = cond;
  endtask

  initial begin
    bit saw_we;
    cyc();
    do_reset();
    chk("reset_ready", {31'd0, rdy_a}, 32'd1);
    chk("reset_we", {31'd0, we_a}, 32'd0);
    chk("reset_retired", {16'd0, ret_a}, 32'd0);

    // ALU op
    drive(2'b00, 2'b00, 1'b1, 3'd5, 16'h1234, 16'h0000, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("alu_we", {31'd0, we_a}, 32'd1);
    chk("alu_waddr", {29'd0, waddr_a}, 32'd5);
    chk("alu_wdata", {16'd0, wdata_a}, 32'h1234);
    chk("alu_retired", {16'd0, ret_a}, 32'd1);
    cyc();
    chk("alu_we_drop", {31'd0, we_a}, 32'd0);

    // COND then PC back-to-back
    do_reset();
    drive(2'b11, 2'b00, 1'b1, 3'd1, 16'hDEAD, 16'hBEEF, 1'b1);
    cyc();
    chk("cond_wdata", {16'd0, wdata_a}, 32'h0001);
    drive(2'b10, 2'b00, 1'b1, 3'd2, 16'hDEAD, 16'h0042, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("pc_we", {31'd0, we_a}, 32'd1);
    chk("pc_wdata", {16'd0, wdata_a}, 32'h0042);
    chk("pc_retired", {16'd0, ret_a}, 32'd2);

    // MEM byte-sign load with a 3-cycle wait; in_valid during the wait is ignored
    do_reset();
    drive(2'b01, 2'b10, 1'b1, 3'd3, 16'h0000, 16'h0000, 1'b0);
    mem_rdata = 16'h1111;
    cyc();
    chk("wait_ready0", {31'd0, rdy_a}, 32'd0);
    drive(2'b00, 2'b00, 1'b1, 3'd7, 16'h5555, 16'h0000, 1'b0);
    cyc();
    cyc();
    chk("wait_ready2", {31'd0, rdy_a}, 32'd0);
    chk("wait_no_we", {31'd0, we_a}, 32'd0);
    mem_done = 1'b1; mem_rdata = 16'hAB80;
    cyc();
    mem_done = 1'b0; in_valid = 1'b0;
    chk("bsx_we", {31'd0, we_a}, 32'd1);
    chk("bsx_waddr", {29'd0, waddr_a}, 32'd3);
    chk("bsx_wdata", {16'd0, wdata_a}, 32'hFF80);
    chk("bsx_retired", {16'd0, ret_a}, 32'd1);
    chk("bsx_ready", {31'd0, rdy_a}, 32'd1);

    // MEM byte-zero load completing in the accept cycle
    do_reset();
    drive(2'b01, 2'b01, 1'b1, 3'd6, 16'h0000, 16'h0000, 1'b0);
    mem_done = 1'b1; mem_rdata = 16'hAB80;
    cyc();
    in_valid = 1'b0; mem_done = 1'b0;
    chk("bzx_wdata", {16'd0, wdata_a}, 32'h0080);
    chk("bzx_ready", {31'd0, rdy_a}, 32'd1);

    // Reset while WAIT_MEM, then a stray mem_done
    do_reset();
    drive(2'b01, 2'b00, 1'b1, 3'd4, 16'h0000, 16'h0000, 1'b0);
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'h7777;
    cyc();
    mem_done = 1'b0;
    chk("rstwait_we", {31'd0, we_a}, 32'd0);
    chk("rstwait_retired", {16'd0, ret_a}, 32'd0);
    chk("rstwait_ready", {31'd0, rdy_a}, 32'd1);

    // Wrap of the 4-bit counter with non-writing ops
    do_reset();
    saw_we = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(2'b00, 2'b00, 1'b0, 3'(i), 16'(i * 3), 16'h0000, 1'b0);
      cyc();
      if (we_a || we_b) saw_we = 1'b1;
    end
    in_valid = 1'b0;
    chk("wrap_no_we", {31'd0, saw_we}, 32'd0);
    chk("wrap_retired4", {28'd0, ret_b}, 32'd1);
    chk("wrap_retired16", {16'd0, ret_a}, 32'd17);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_src       = 2'($urandom);
      in_ld_mode   = 2'($urandom);
      in_reg_write = 1'($urandom);
      in_rd        = 3'($urandom);
      in_data      = 16'($urandom);
      in_pc_inc    = 16'($urandom);
      in_cond      = 1'($urandom);
      mem_done     = ($urandom_range(0, 2) == 0);
      mem_rdata    = 16'($urandom);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; mem_done = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
